oc8051_prog_mem: RTL and testbench

Parametrised program-memory fetch unit for the oc8051 core. It sits between the instruction-fetch stage and program storage. It returns a 32-bit, four-byte little-endian fetch window from either the on-chip synchronous ROM or a byte-wide external program bus with programmable wait states. It also reports whether the last fetch was served internally. Internal hits sustain one fetch per cycle; external fetches are multi-cycle and assemble four bytes.

---
 rtl/oc8051_pkg.sv | 21 ++
 rtl/oc8051_rom_array.sv | 64 ++++++
 rtl/oc8051_prog_mem.sv | 205 ++++++++++++++++++++
 tb/tb_oc8051_prog_mem.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_pkg.sv
// ---------------------------------------------------------------------------
// oc8051_pkg
//   Shared definitions for the oc8051 program-memory fetch unit:
//   - pm_state_e : fetch sequencer states (IDLE, INT, EXT, DONE)
//   - WIN_BYTES  : bytes per fetch window
//   - NOP_OPCODE : 8051 NOP, returned for windows that cannot be served
// ---------------------------------------------------------------------------
package oc8051_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT  = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } pm_state_e;

  localparam int WIN_BYTES = 4;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

endpackage : oc8051_pkg

// File: rtl/oc8051_rom_array.sv
// ---------------------------------------------------------------------------
// oc8051_rom_array
//   On-chip program ROM organised as four byte-wide lanes. Lane j holds every
//   byte whose address has [1:0] == j, so any four consecutive bytes live in
//   four different lanes and can be read in one cycle. Each lane output is
//   registered (one-cycle latency); the parent rotates lanes into window
//   order using the low address bits of the accepted request.
//
//   The lane storage (mem) is preloaded from the byte image named by ROM_INIT
//   by the surrounding load flow; it has no write port.
//
// Parameters:
//   INT_ROM_WID : byte address width of the internal ROM (8..15)
//   ROM_INIT    : name of the byte image for this ROM
// Ports:
//   clk       in   rising-edge clock
//   rd_addr   in   byte address of window byte 0
//   lane_data out  registered lane bytes, lane j at [8j+7:8j]
// ---------------------------------------------------------------------------
module oc8051_rom_array
  import oc8051_pkg::*;
#(
  parameter int INT_ROM_WID = 12,
  parameter     ROM_INIT    = "oc8051_rom.hex"
) (
  input  logic                   clk,
  input  logic [INT_ROM_WID-1:0] rd_addr,
  output logic [31:0]            lane_data
);

  localparam int IdxW      = INT_ROM_WID - 2;
  localparam int LaneDepth = 1 << IdxW;

  if ($bits(ROM_INIT) == 0) begin : g_bad_image
    $error("oc8051_rom_array: ROM_INIT must name a byte image");
  end

  logic [7:0] mem [WIN_BYTES][LaneDepth];

  logic [31:0]            lane_data_d;
  logic [31:0]            lane_data_q;
  logic [1:0]             lane_ofs;
  logic [INT_ROM_WID-1:0] lane_sum;

  // Lane j serves the window byte at addr + ((j - addr[1:0]) & 3); that byte's
  // row inside the lane is its address with the two lane-select bits dropped.
  always_comb begin
    lane_data_d = '0;
    lane_ofs    = '0;
    lane_sum    = '0;
    for (int j = 0; j < WIN_BYTES; j++) begin
      lane_ofs = 2'(j) - rd_addr[1:0];
      lane_sum = rd_addr + {{IdxW{1'b0}}, lane_ofs};
      lane_data_d[8*j +: 8] = mem[j][lane_sum[INT_ROM_WID-1:2]];
    end
  end

  always_ff @(posedge clk) begin
    lane_data_q <= lane_data_d;
  end

  assign lane_data = lane_data_q;

endmodule : oc8051_rom_array

// File: rtl/oc8051_prog_mem.sv
// ---------------------------------------------------------------------------
// oc8051_prog_mem
//   Program-memory fetch unit. Returns a four-byte little-endian window
//   starting at addr, either from the on-chip ROM (one window per cycle) or,
//   when the window is not fully inside the ROM or ea_in=0, from a byte-wide
//   external program bus with EXT_WAIT extra wait cycles per byte.
//
//   Build option OC8051_XROM_EN:
//     defined   : external windows are fetched over ext_addr/ext_rd/ext_data_i
//     undefined : external windows ack after one cycle with four NOPs and the
//                 external bus outputs are held at 0
//
// Parameters:
//   INT_ROM_WID : internal ROM address width (8..15)
//   EXT_WAIT    : extra wait cycles per external byte (0..15)
//   ROM_INIT    : internal ROM byte image
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   ea_in       external-access pin, 0 forces external fetches
//   req, addr   fetch request and window start address (sampled when !busy)
//   busy        external transaction in progress, req ignored
//   ack, data_o one-cycle completion pulse and the window data
//   ea_int      1 when the last accepted window was served internally
//   ext_addr, ext_rd, ext_data_i   external program bus
// ---------------------------------------------------------------------------
module oc8051_prog_mem
  import oc8051_pkg::*;
#(
  parameter int INT_ROM_WID = 12,
  parameter int EXT_WAIT    = 2,
  parameter     ROM_INIT    = "oc8051_rom.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ea_in,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        ack,
  output logic [31:0] data_o,
  output logic        ea_int,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  input  logic [7:0]  ext_data_i
);

  if (INT_ROM_WID < 8 || INT_ROM_WID > 15) begin : g_bad_wid
    $error("oc8051_prog_mem: INT_ROM_WID must be 8..15");
  end
  if (EXT_WAIT < 0 || EXT_WAIT > 15) begin : g_bad_wait
    $error("oc8051_prog_mem: EXT_WAIT must be 0..15");
  end

  localparam logic [16:0] IntLimit  = 17'd1 << INT_ROM_WID;
  localparam logic [31:0] NopWindow = {WIN_BYTES{NOP_OPCODE}};

  pm_state_e   state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        ea_int_q, ea_int_d;

  logic        accept;
  logic        win_internal;
  logic [16:0] win_last;
  logic [31:0] rom_lanes;
  logic [31:0] rom_window;
  logic [1:0]  lane_sel;

`ifdef OC8051_XROM_EN
  localparam logic [3:0] WaitLast = 4'(EXT_WAIT);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] asm_q, asm_d;
`else
  logic unused_xrom;
  assign unused_xrom = ^{ext_data_i, addr_q[15:2]};
`endif

  oc8051_rom_array #(
    .INT_ROM_WID (INT_ROM_WID),
    .ROM_INIT    (ROM_INIT)
  ) u_rom (
    .clk       (clk),
    .rd_addr   (addr[INT_ROM_WID-1:0]),
    .lane_data (rom_lanes)
  );

  // The last window byte is computed one bit wider so a window running past
  // 0xFFFF can never look internal; if the last byte fits, all four do.
  assign win_last     = {1'b0, addr} + 17'd3;
  assign win_internal = ea_in && (win_last < IntLimit);

  assign busy   = (state_q == ST_EXT) || (state_q == ST_DONE);
  assign accept = req && !busy;
  assign ea_int = ea_int_q;

  // Window byte k sits in lane (addr[1:0] + k) mod 4 of the registered ROM
  // output, using the offset of the window that was accepted last cycle.
  always_comb begin
    rom_window = '0;
    lane_sel   = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      lane_sel = addr_q[1:0] + 2'(k);
      rom_window[8*k +: 8] = rom_lanes[{lane_sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ea_int_d = ea_int_q;
    ack      = 1'b0;
    data_o   = '0;
    ext_rd   = 1'b0;
    ext_addr = '0;
`ifdef OC8051_XROM_EN
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    asm_d      = asm_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
      end

      // INT also carries external-classified windows when the external
      // path is not built; ea_int_q then selects the NOP window.
      ST_INT: begin
        ack     = 1'b1;
        data_o  = ea_int_q ? rom_window : NopWindow;
        state_d = ST_IDLE;
      end

`ifdef OC8051_XROM_EN
      // Each byte holds its address for EXT_WAIT+1 cycles and captures the
      // bus on the last of them; the strobe stays up across all four bytes.
      ST_EXT: begin
        ext_rd   = 1'b1;
        ext_addr = addr_q + {14'd0, byte_cnt_q};
        if (wait_cnt_q == WaitLast) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = ext_data_i;
          wait_cnt_d = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_DONE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        ack     = 1'b1;
        data_o  = asm_q;
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Acceptance only happens in IDLE or INT (busy is low there), so an
    // internal stream can issue a new window in the same cycle as the ack.
    if (accept) begin
      addr_d   = addr;
      ea_int_d = win_internal;
`ifdef OC8051_XROM_EN
      state_d    = win_internal ? ST_INT : ST_EXT;
      byte_cnt_d = '0;
      wait_cnt_d = '0;
`else
      state_d = ST_INT;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      ea_int_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ea_int_q <= ea_int_d;
    end
  end

`ifdef OC8051_XROM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      asm_q      <= asm_d;
    end
  end
`endif

endmodule : oc8051_prog_mem

// File: tb/tb_oc8051_prog_mem.sv
// ---------------------------------------------------------------------------
// tb_oc8051_prog_mem
//   Directed bench for oc8051_prog_mem with INT_ROM_WID=12, EXT_WAIT=2.
//   Expectations follow the OC8051_XROM_EN build setting of the design.
// ---------------------------------------------------------------------------
module tb_oc8051_prog_mem;

  localparam int ROM_WID  = 12;
  localparam int WAIT_CYC = 2;
  localparam int BYTE_CYC = WAIT_CYC + 1;
  localparam int ROM_SIZE = 1 << ROM_WID;

  logic        clk;
  logic        rst;
  logic        ea_in;
  logic        req;
  logic [15:0] addr;
  logic        busy;
  logic        ack;
  logic [31:0] data_o;
  logic        ea_int;
  logic [15:0] ext_addr;
  logic        ext_rd;
  logic [7:0]  ext_data_i;

  int checks;
  int errors;

  logic [7:0] rom_model [ROM_SIZE];

  oc8051_prog_mem #(
    .INT_ROM_WID (ROM_WID),
    .EXT_WAIT    (WAIT_CYC),
    .ROM_INIT    ("oc8051_rom.hex")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ea_in      (ea_in),
    .req        (req),
    .addr       (addr),
    .busy       (busy),
    .ack        (ack),
    .data_o     (data_o),
    .ea_int     (ea_int),
    .ext_addr   (ext_addr),
    .ext_rd     (ext_rd),
    .ext_data_i (ext_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ext_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rom_win(input int a);
    return {rom_model[a+3], rom_model[a+2], rom_model[a+1], rom_model[a]};
  endfunction

  function automatic logic [31:0] ext_win(input logic [15:0] a);
    return {ext_byte(a + 16'd3), ext_byte(a + 16'd2), ext_byte(a + 16'd1), ext_byte(a)};
  endfunction

  // External memory model: drives valid data only in the last cycle of each
  // byte strobe, garbage otherwise, so early sampling shows up in data_o.
  int          strobe_cnt;
  logic        prev_rd;
  logic [15:0] prev_addr;
  initial begin
    strobe_cnt = 0;
    prev_rd    = 1'b0;
    prev_addr  = '0;
    ext_data_i = 8'hEE;
  end
  always @(negedge clk) begin
    if (ext_rd && prev_rd && ext_addr == prev_addr) strobe_cnt = strobe_cnt + 1;
    else strobe_cnt = 0;
    prev_rd   = ext_rd;
    prev_addr = ext_addr;
    ext_data_i = (ext_rd && strobe_cnt == WAIT_CYC) ? ext_byte(ext_addr) : 8'hEE;
  end

  task automatic load_rom();
    logic [7:0] v;
    for (int a = 0; a < ROM_SIZE; a++) begin
      case (a)
        16'h10:  v = 8'h11;
        16'h11:  v = 8'h22;
        16'h12:  v = 8'h33;
        16'h13:  v = 8'h44;
        default: v = 8'((a * 37 + 5) ^ (a >> 4));
      endcase
      rom_model[a] = v;
      dut.u_rom.mem[a % 4][a / 4] = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; ea_in = 1'b1; addr = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %0b want 0", ack); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", data_o); end
    checks++; if (ea_int !== 1'b1) begin errors++; $display("[TB] FAIL reset_ea_int got %0b want 1", ea_int); end
    checks++; if (ext_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_ext_rd got %0b want 0", ext_rd); end
    checks++; if (ext_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_ext_addr got %h want 0", ext_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_internal_single();
    req = 1'b1; addr = 16'h0010; ea_in = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle got %0b want 0", busy); end
    @(negedge clk);
    req = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL single_ack got %0b want 1", ack); end
    checks++; if (data_o !== 32'h44332211) begin errors++; $display("[TB] FAIL single_data got %h want 44332211", data_o); end
    checks++; if (ea_int !== 1'b1) begin errors++; $display("[TB] FAIL single_ea_int got %0b want 1", ea_int); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %0b want 0", busy); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_drop got %0b want 0", ack); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [5];
    seq[0] = 16'h0000; seq[1] = 16'h0004; seq[2] = 16'h0008;
    seq[3] = 16'h0011; seq[4] = 16'h0FFC;
    req = 1'b1; ea_in = 1'b1; addr = seq[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) addr = seq[i+1];
      else req = 1'b0;
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack[%0d] got %0b want 1", i, ack); end
      checks++; if (data_o !== rom_win(int'(seq[i]))) begin
        errors++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, data_o, rom_win(int'(seq[i]))); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy[%0d] got %0b want 0", i, busy); end
    end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack_drop got %0b want 0", ack); end
  endtask

  // Issues one external-classified window and checks the whole transaction.
  // With hold_req the request stays asserted (to another address) afterwards.
  task automatic run_external(input string name, input logic [15:0] a, input logic pin, input logic hold_req);
    req = 1'b1; addr = a; ea_in = pin;
`ifdef OC8051_XROM_EN
    for (int i = 1; i <= 4 * BYTE_CYC; i++) begin
      @(negedge clk);
      ea_in = 1'b1;
      if (hold_req) addr = 16'h0010;
      else req = 1'b0;
      checks++; if (ext_rd !== 1'b1) begin errors++; $display("[TB] FAIL %s_ext_rd[%0d] got %0b want 1", name, i, ext_rd); end
      checks++; if (ext_addr !== a + 16'((i - 1) / BYTE_CYC)) begin
        errors++; $display("[TB] FAIL %s_ext_addr[%0d] got %h want %h", name, i, ext_addr, a + 16'((i - 1) / BYTE_CYC)); end
      checks++; if (ack !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL %s_wait[%0d] got ack=%0b busy=%0b want ack=0 busy=1", name, i, ack, busy); end
    end
    @(negedge clk);
    req = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL %s_ack got %0b want 1", name, ack); end
    checks++; if (data_o !== ext_win(a)) begin errors++; $display("[TB] FAIL %s_data got %h want %h", name, data_o, ext_win(a)); end
    checks++; if (ext_rd !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_rd got %0b want 0", name, ext_rd); end
    checks++; if (ea_int !== 1'b0) begin errors++; $display("[TB] FAIL %s_ea_int got %0b want 0", name, ea_int); end
    @(negedge clk);
    checks++; if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_idle got ack=%0b busy=%0b want 0 0", name, ack, busy); end
`else
    @(negedge clk);
    ea_in = 1'b1;
    if (hold_req) addr = 16'h0010;
    else req = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL %s_ack got %0b want 1", name, ack); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("[TB] FAIL %s_nop got %h want 0", name, data_o); end
    checks++; if (ea_int !== 1'b0) begin errors++; $display("[TB] FAIL %s_ea_int got %0b want 0", name, ea_int); end
    checks++; if (ext_rd !== 1'b0 || ext_addr !== 16'h0) begin
      errors++; $display("[TB] FAIL %s_bus got rd=%0b addr=%h want 0 0", name, ext_rd, ext_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy got %0b want 0", name, busy); end
    @(negedge clk);
    req = 1'b0;
    if (hold_req) begin
      checks++; if (ack !== 1'b1 || data_o !== 32'h44332211 || ea_int !== 1'b1) begin
        errors++; $display("[TB] FAIL %s_follow got ack=%0b data=%h ea_int=%0b want 1 44332211 1", name, ack, data_o, ea_int); end
      @(negedge clk);
    end
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL %s_ack_drop got %0b want 0", name, ack); end
`endif
  endtask

  task automatic test_boundary_straddle();
    run_external("straddle", 16'h0FFE, 1'b1, 1'b0);
  endtask

  task automatic test_forced_external();
    run_external("forced", 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_around();
    run_external("wrap", 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 16'h2000; ea_in = 1'b1;
`ifdef OC8051_XROM_EN
    for (int i = 1; i <= 2 * BYTE_CYC + 1; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    checks++; if (ext_addr !== 16'h2002 || ea_int !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_pre got addr=%h ea_int=%0b want 2002 0", ext_addr, ea_int); end
`else
    @(negedge clk);
    req = 1'b0;
    checks++; if (ack !== 1'b1 || ea_int !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_pre got ack=%0b ea_int=%0b want 1 0", ack, ea_int); end
`endif
    rst = 1'b1;
    #1;
    checks++; if (ext_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ext_rd got %0b want 0", ext_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0b want 0", busy); end
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack got %0b want 0", ack); end
    checks++; if (ea_int !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ea_int got %0b want 1", ea_int); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_ack[%0d] got %0b want 0", i, ack); end
    end
    req = 1'b1; addr = 16'h0010; ea_in = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++; if (ack !== 1'b1 || data_o !== 32'h44332211) begin
      errors++; $display("[TB] FAIL rstmid_recover got ack=%0b data=%h want 1 44332211", ack, data_o); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 1'b0;
    ea_in  = 1'b1;
    addr   = '0;
    load_rom();
    test_reset();
    test_internal_single();
    test_back_to_back();
    test_boundary_straddle();
    test_forced_external();
    test_wrap_around();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_oc8051_prog_mem
